// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add multiply.
// Results and flags are registered and held until the next operation completes.
module alu_seq #(
  parameter int M      = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [2:0]   selection,
  input  logic [M-1:0] rga,
  input  logic [M-1:0] rgb,
  output logic [M-1:0] res,
  output logic         carry,
  output logic         ov,
  output logic         neg,
  output logic         zero,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_o
);

  // Handshake: start is a request honoured only while busy=0 (IDLE); it is
  // accepted on that rising edge. done pulses for exactly one cycle and
  // res/flags are valid while it is high; they hold afterwards.

  localparam int             SW     = $clog2(M);
  localparam logic [SW-1:0]  LAST   = SW'(M - 1);
  localparam logic [2:0]     OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [M-1:0]     a_q;
  logic [2:0]       op_q;
  logic [2*M-1:0]   prod_q;
  logic [SW-1:0]    cnt_q;
  logic [M-1:0]     res_q;
  logic             carry_q, ov_q, neg_q, zero_q;

  logic [M-1:0]     alu_res;
  logic             alu_c, alu_v;
  logic [M:0]       wide;
  logic [SW-1:0]    shamt;
  logic [M:0]       mul_sum;
  logic [2*M-1:0]   prod_d;

  assign shamt = rgb[SW-1:0];

  always_comb begin
    alu_res = rga;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    case (selection)
      3'd1: begin
        wide    = {1'b0, rga} + {1'b0, rgb};
        alu_res = wide[M-1:0];
        alu_c   = wide[M];
        alu_v   = (rga[M-1] == rgb[M-1]) && (alu_res[M-1] != rga[M-1]);
      end
      3'd2: alu_res = rga & rgb;
      3'd3: alu_res = rga | rgb;
      3'd4: begin
        // bit M of the widened difference is the borrow
        wide    = {1'b0, rga} - {1'b0, rgb};
        alu_res = wide[M-1:0];
        alu_c   = wide[M];
        alu_v   = (rga[M-1] != rgb[M-1]) && (alu_res[M-1] != rga[M-1]);
      end
      3'd5: alu_res = rga ^ rgb;
      3'd6: begin
        // the last bit shifted out lands in bit M; zero for amount 0
        wide    = {1'b0, rga} << shamt;
        alu_res = wide[M-1:0];
        alu_c   = wide[M];
      end
      default: alu_res = rga;
    endcase
  end

  // One shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (LSB) is set, then shift the whole product right by one.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*M-1:M]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_d  = {mul_sum, prod_q[M-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      op_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q    <= rga;
            op_q   <= selection;
            prod_q <= {{M{1'b0}}, rgb};
            cnt_q  <= '0;
            if (MUL_EN && (selection == OP_MUL)) begin
              state_q <= S_MUL;
            end else begin
              res_q   <= alu_res;
              carry_q <= alu_c;
              ov_q    <= alu_v;
              neg_q   <= alu_res[M-1];
              zero_q  <= (alu_res == '0);
              state_q <= S_DONE;
            end
          end
        end
        S_MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
          if ((cnt_q == LAST) || (op_q != OP_MUL)) begin
            res_q   <= prod_d[M-1:0];
            carry_q <= |prod_d[2*M-1:M];
            ov_q    <= 1'b0;
            neg_q   <= prod_d[M-1];
            zero_q  <= (prod_d[M-1:0] == '0);
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res     = res_q;
  assign carry   = carry_q;
  assign ov      = ov_q;
  assign neg     = neg_q;
  assign zero    = zero_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: M=8 with multiplier, plus a MUL_EN=0 instance.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_a, start_b;
  logic [2:0] selection;
  logic [7:0] rga, rgb;

  logic [7:0] res_a, res_b;
  logic       carry_a, ov_a, neg_a, zero_a, busy_a, done_a;
  logic       carry_b, ov_b, neg_b, zero_b, busy_b, done_b;
  logic [1:0] state_a, state_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.M(8), .MUL_EN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .selection(selection),
    .rga(rga), .rgb(rgb), .res(res_a), .carry(carry_a), .ov(ov_a),
    .neg(neg_a), .zero(zero_a), .busy(busy_a), .done(done_a), .state_o(state_a)
  );

  alu_seq #(.M(8), .MUL_EN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .selection(selection),
    .rga(rga), .rgb(rgb), .res(res_b), .carry(carry_b), .ov(ov_b),
    .neg(neg_b), .zero(zero_b), .busy(busy_b), .done(done_b), .state_o(state_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, return at the negedge where done is seen; lat=1 means the
  // cycle right after the accepting edge.
  task automatic run_op(input bit use_b, input logic [2:0] sel,
                        input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    selection = sel; rga = a; rgb = b;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    lat = 1;
    while (!(use_b ? done_b : done_a) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!(use_b ? done_b : done_a)) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_a(input string tag, input int lat, input int exp_lat,
                       input logic [7:0] r, input logic c, input logic v,
                       input logic n, input logic z);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, res_a, r);
    check({tag, "_flags"}, {carry_a, ov_a, neg_a, zero_a}, {c, v, n, z});
  endtask

  initial begin
    int lat, busy_cnt, done_cnt, done_cyc, held_bad;
    reset_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    selection = 3'd1; rga = 8'h12; rgb = 8'h34;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_res", res_a, 8'h00);
    check("rst_flags", {carry_a, ov_a, neg_a, zero_a}, 4'b0001);
    check("rst_state", state_a, 2'd0);
    start_a = 1'b0; start_b = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    check("rst_start_ignored", busy_a, 1'b0);

    run_op(1'b0, 3'd1, 8'h7F, 8'h01, lat); chk_a("add_7f_01", lat, 1, 8'h80, 0, 1, 1, 0);
    @(negedge clk);
    check("done_pulse_one", done_a, 1'b0);
    check("idle_after_done", busy_a, 1'b0);
    run_op(1'b0, 3'd1, 8'hFF, 8'h01, lat); chk_a("add_ff_01", lat, 1, 8'h00, 1, 0, 0, 1);
    run_op(1'b0, 3'd4, 8'h05, 8'h07, lat); chk_a("sub_05_07", lat, 1, 8'hFE, 1, 0, 1, 0);
    run_op(1'b0, 3'd4, 8'h80, 8'h01, lat); chk_a("sub_80_01", lat, 1, 8'h7F, 0, 1, 0, 0);
    run_op(1'b0, 3'd1, 8'h80, 8'h80, lat); chk_a("add_80_80", lat, 1, 8'h00, 1, 1, 0, 1);
    run_op(1'b0, 3'd6, 8'h81, 8'h01, lat); chk_a("shl_81_1", lat, 1, 8'h02, 1, 0, 0, 0);
    run_op(1'b0, 3'd6, 8'h81, 8'h00, lat); chk_a("shl_81_0", lat, 1, 8'h81, 0, 0, 1, 0);
    run_op(1'b0, 3'd6, 8'h03, 8'hF7, lat); chk_a("shl_03_7", lat, 1, 8'h80, 1, 0, 1, 0);
    run_op(1'b0, 3'd2, 8'hF0, 8'h3C, lat); chk_a("and", lat, 1, 8'h30, 0, 0, 0, 0);
    run_op(1'b0, 3'd3, 8'hF0, 8'h0F, lat); chk_a("or", lat, 1, 8'hFF, 0, 0, 1, 0);
    run_op(1'b0, 3'd5, 8'hAA, 8'hFF, lat); chk_a("xor", lat, 1, 8'h55, 0, 0, 0, 0);
    run_op(1'b0, 3'd0, 8'h5A, 8'hC3, lat); chk_a("pass", lat, 1, 8'h5A, 0, 0, 0, 0);

    // multiply 0x10*0x11 with a stray start mid-MUL; previous result 0x5A held
    @(negedge clk);
    selection = 3'd7; rga = 8'h10; rgb = 8'h11; start_a = 1'b1;
    @(posedge clk);
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; held_bad = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      start_a = (cyc == 4);
      if (cyc == 4) begin selection = 3'd1; rga = 8'h01; rgb = 8'h01; end
      if (cyc == 1) check("mul_state", state_a, 2'd1);
      if (busy_a) busy_cnt++;
      if (done_a) begin done_cnt++; done_cyc = cyc; end
      if (cyc <= 8 && (res_a !== 8'h5A || zero_a !== 1'b0)) held_bad++;
      if (cyc == 9) begin
        check("mul_res", res_a, 8'h10);
        check("mul_flags", {carry_a, ov_a, neg_a, zero_a}, 4'b1000);
      end
    end
    start_a = 1'b0;
    check("mul_busy_cycles", busy_cnt, 9);
    check("mul_done_cycle", done_cyc, 9);
    check("mul_done_count", done_cnt, 1);
    check("mul_res_held", held_bad, 0);

    run_op(1'b0, 3'd7, 8'hFF, 8'hFF, lat); chk_a("mul_ff_ff", lat, 9, 8'h01, 1, 0, 0, 0);
    run_op(1'b0, 3'd7, 8'h05, 8'h01, lat); chk_a("mul_by_1", lat, 9, 8'h05, 0, 0, 0, 0);
    run_op(1'b0, 3'd7, 8'h37, 8'h00, lat); chk_a("mul_by_0", lat, 9, 8'h00, 0, 0, 0, 1);
    run_op(1'b0, 3'd7, 8'h0D, 8'h0B, lat); chk_a("mul_0d_0b", lat, 9, 8'h8F, 0, 0, 1, 0);

    // reset asserted in MUL cycle 4 aborts the operation
    run_op(1'b0, 3'd1, 8'h20, 8'h22, lat); chk_a("add_pre_rst", lat, 1, 8'h42, 0, 0, 0, 0);
    @(negedge clk);
    selection = 3'd7; rga = 8'h10; rgb = 8'h11; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk); start_a = 1'b0;
    repeat (3) @(negedge clk);
    check("mul4_busy", busy_a, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    check("abort_res", res_a, 8'h00);
    check("abort_zero", zero_a, 1'b1);
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // MUL_EN=0: opcode 7 behaves as pass-A
    run_op(1'b1, 3'd7, 8'h3C, 8'h05, lat);
    check("nomul_lat", lat, 1);
    check("nomul_res", res_b, 8'h3C);
    check("nomul_flags", {carry_b, ov_b, neg_b, zero_b}, 4'b0000);
    check("nomul_a_idle", busy_a, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter M, default 8: operand/result width in bits; legal range M >= 4.
REQ-002 SHALL have parameter MUL_EN, default 1: 1 = iterative multiply present; 0 = opcode 7 executes as pass-A.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 SHALL have port start  input  1  operation request, accepted only in IDLE.
REQ-006 SHALL have port selection  input  3  opcode: 0 pass A, 1 add, 2 and, 3 or, 4 sub, 5 xor, 6 shift-left, 7 multiply.
REQ-007 SHALL have ports rga, rgb  input  M each  operands, sampled on the accepting edge.
REQ-008 SHALL have port res  output  M  registered result.
REQ-009 SHALL have ports carry, ov, neg, zero  output  1 each  registered flags.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse; res and flags are valid while high.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DONE.
REQ-013 IDLE with start=1 SHALL latch rga, rgb and selection into internal registers; start=0 keeps IDLE.
REQ-014 Opcodes 0-6, and 7 with MUL_EN=0: IDLE -> DONE on the accepting edge; res and flags updated on that edge; done=1 in the next cycle (latency 1).
REQ-015 Opcode 7 with MUL_EN=1: IDLE -> MUL; shift-add, one multiplier bit per cycle, exactly M cycles in MUL, then -> DONE; done high M+1 cycles after the accepting edge.
REQ-016 DONE SHALL return to IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-017 start while busy=1 SHALL be ignored and have no effect on the operation in progress.
REQ-018 res and flags SHALL hold their values from the last completed operation until the next result update; they SHALL NOT change during MUL.
REQ-019 add: {carry,res} = A+B (M+1 bits); ov = signed overflow (A,B same sign, res sign differs).
REQ-020 sub: res = A-B mod 2^M; carry = borrow (1 iff A<B unsigned); ov = 1 iff A,B signs differ and res sign differs from A.
REQ-021 shift-left: amount = rgb[clog2(M)-1:0]; res = A<<amount; carry = last bit shifted out, 0 when amount=0; ov=0.
REQ-022 multiply: unsigned; res = low M bits of A*B; carry = 1 iff high M bits nonzero; ov=0.
REQ-023 pass A, and, or, xor: carry=0, ov=0.
REQ-024 All opcodes: neg = res[M-1]; zero = (res == 0).
REQ-025 Multiply by 0 or by 1 SHALL still take the full M cycles (fixed latency).

Reset
REQ-026 On a rising edge with reset_n=0: state -> IDLE; res=0; carry=0; ov=0; neg=0; zero=1; busy=0; done=0; internal operand and multiply registers cleared.
REQ-027 Reset asserted in MUL or DONE SHALL abort the operation; no done pulse follows.
REQ-028 start sampled on the same edge as reset_n=0 SHALL be ignored.

Verification
REQ-029 M=8, add 0x7F+0x01 -> res=0x80, ov=1, neg=1, carry=0, zero=0, done one cycle after start.
REQ-030 M=8, add 0xFF+0x01 -> res=0x00, carry=1, zero=1, ov=0; then sub 0x05-0x07 -> res=0xFE, carry=1, neg=1, ov=0.
REQ-031 M=8, shift-left 0x81 by rgb=0x01 -> res=0x02, carry=1; shift by 0 -> res=0x81, carry=0, neg=1.
REQ-032 M=8, multiply 0x10*0x11 -> busy high 9 cycles, done exactly 9 cycles after the accepting edge, res=0x10, carry=1; start pulsed mid-MUL has no effect.
REQ-033 M=8, reset_n=0 during MUL cycle 4 -> next cycle busy=0, done=0, res=0x00, zero=1; no later done pulse.
REQ-034 M=8, MUL_EN=0, opcode 7 with A=0x3C -> res=0x3C, done one cycle after start, carry=0.
